// File: rtl/timer_tick_scheduler.sv
// Sequences an Avalon interval timer: load/start, per-timeout ack, 64-bit snapshot, stop.
// Bus outputs are registered from the next state, so each write appears in the state that owns it.
module timer_tick_scheduler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] cfg_period,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        snap_req,
    output logic        busy,
    output logic        tick_pulse,
    output logic [31:0] tick_count,
    output logic [63:0] snap_value,
    output logic        snap_valid,
    output logic [3:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        timer_irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_LD0, S_LD1, S_LD2, S_LD3, S_CTRL, S_RUN, S_ACK,
        S_SNW, S_SR0, S_SR1, S_SR2, S_SR3, S_SR4, S_STOPW
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] period_q, period_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic [63:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
    logic        pend_stop_q, pend_stop_d;
    logic        pend_start_q, pend_start_d;
    logic [3:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [15:0] wdata_q, wdata_d;
    logic        start_go;
    logic        eff_stop;
    logic        eff_start;
    logic        in_seq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign eff_stop  = cfg_stop | pend_stop_q;
    assign eff_start = cfg_start | pend_start_q;

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d  = S_LD0;
                    start_go = 1'b1;
                end
            end
            S_LD0:  state_d = S_LD1;
            S_LD1:  state_d = S_LD2;
            S_LD2:  state_d = S_LD3;
            S_LD3:  state_d = S_CTRL;
            S_CTRL: state_d = S_RUN;
            S_RUN: begin
                if (eff_stop) begin
                    state_d = S_STOPW;
                end else if (eff_start) begin
                    state_d  = S_LD0;
                    start_go = 1'b1;
                end else if (timer_irq) begin
                    state_d = S_ACK;
                end else if (snap_req) begin
                    state_d = S_SNW;
                end
            end
            S_ACK:   state_d = S_RUN;
            S_SNW:   state_d = S_SR0;
            S_SR0:   state_d = S_SR1;
            S_SR1:   state_d = S_SR2;
            S_SR2:   state_d = S_SR3;
            S_SR3:   state_d = S_SR4;
            S_SR4:   state_d = S_RUN;
            S_STOPW: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 4'd0;
        wdata_d = 16'd0;
        case (state_d)
            S_LD0:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd2; wdata_d = period_d[15:0];  end
            S_LD1:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd3; wdata_d = period_d[31:16]; end
            S_LD2:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd4; wdata_d = period_d[47:32]; end
            S_LD3:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd5; wdata_d = period_d[63:48]; end
            S_CTRL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0007; end
            S_ACK:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd0; wdata_d = 16'h0000; end
            S_SNW:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd6; wdata_d = 16'h0000; end
            S_SR0:   addr_d = 4'd6;
            S_SR1:   addr_d = 4'd7;
            S_SR2:   addr_d = 4'd8;
            S_SR3:   addr_d = 4'd9;
            S_STOPW: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0008; end
            default: ;
        endcase
    end

    // Requests arriving mid-sequence are held one deep; a held stop discards a held start.
    assign in_seq = (state_q != S_IDLE) && (state_q != S_RUN) && (state_q != S_STOPW);

    always_comb begin
        pend_stop_d  = 1'b0;
        pend_start_d = 1'b0;
        if (in_seq) begin
            pend_stop_d  = pend_stop_q | cfg_stop;
            pend_start_d = (pend_start_q | cfg_start) & ~(pend_stop_q | cfg_stop);
        end
    end

    always_comb begin
        period_d     = start_go ? cfg_period : period_q;
        tick_count_d = tick_count_q;
        if (start_go) begin
            tick_count_d = 32'd0;
        end else if (state_d == S_ACK) begin
            tick_count_d = tick_count_q + 32'd1;
        end
        snap_value_d = snap_value_q;
        case (state_q)
            S_SR1:   snap_value_d[15:0]  = avm_readdata;
            S_SR2:   snap_value_d[31:16] = avm_readdata;
            S_SR3:   snap_value_d[47:32] = avm_readdata;
            S_SR4:   snap_value_d[63:48] = avm_readdata;
            default: ;
        endcase
        snap_valid_d = (state_q == S_SR4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q     <= 64'd0;
            tick_count_q <= 32'd0;
            snap_value_q <= 64'd0;
            snap_valid_q <= 1'b0;
            pend_stop_q  <= 1'b0;
            pend_start_q <= 1'b0;
            addr_q       <= 4'd0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wdata_q      <= 16'd0;
        end else begin
            period_q     <= period_d;
            tick_count_q <= tick_count_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            pend_stop_q  <= pend_stop_d;
            pend_start_q <= pend_start_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign tick_pulse     = (state_q == S_ACK);
    assign tick_count     = tick_count_q;
    assign snap_value     = snap_value_q;
    assign snap_valid     = snap_valid_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler with an Avalon timer slave model and a write scoreboard.
module tb_timer_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [63:0] cfg_period = 64'd0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        snap_req = 1'b0;
    logic        timer_irq = 1'b0;
    logic        busy, tick_pulse, snap_valid;
    logic [31:0] tick_count;
    logic [63:0] snap_value;
    logic [3:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'd0;

    int          checks = 0;
    int          errors = 0;
    int          n_pulse = 0;
    int          n_snapv = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mod_ticks = 32'd0;
    logic [19:0] exp_q[$];
    logic [63:0] slave_cnt = 64'd0;
    logic [63:0] slave_snap = 64'd0;

    timer_tick_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_period     (cfg_period),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .snap_req       (snap_req),
        .busy           (busy),
        .tick_pulse     (tick_pulse),
        .tick_count     (tick_count),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timer slave: writing SNAPL latches the counter; reads return one cycle after the address.
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 4'd6)
            slave_snap <= slave_cnt;
        case (avm_address)
            4'd6:    avm_readdata <= slave_snap[15:0];
            4'd7:    avm_readdata <= slave_snap[31:16];
            4'd8:    avm_readdata <= slave_snap[47:32];
            4'd9:    avm_readdata <= slave_snap[63:48];
            default: avm_readdata <= 16'd0;
        endcase
    end

    // Expected-write scoreboard and tick/snapshot bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        logic [19:0] e;
        if (!reset_n) begin
            mod_ticks = 32'd0;
        end else if (mon_en) begin
            if (avm_chipselect) begin
                check("wr_write_n", {63'd0, avm_write_n}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {44'd0, avm_address, avm_writedata}, 64'hFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {60'd0, avm_address}, {60'd0, e[19:16]});
                    check("wr_data", {48'd0, avm_writedata}, {48'd0, e[15:0]});
                end
                if (avm_address == 4'd2) mod_ticks = 32'd0;
            end else begin
                check("idle_write_n", {63'd0, avm_write_n}, 64'd1);
                check("idle_wdata", {48'd0, avm_writedata}, 64'd0);
            end
            if (tick_pulse) begin
                mod_ticks = mod_ticks + 32'd1;
                n_pulse++;
            end
            if (snap_valid) n_snapv++;
            check("tick_count_model", {32'd0, tick_count}, {32'd0, mod_ticks});
        end
    end

    task automatic do_start(input logic [63:0] period, input logic with_stop);
        exp_q.push_back({4'd2, period[15:0]});
        exp_q.push_back({4'd3, period[31:16]});
        exp_q.push_back({4'd4, period[47:32]});
        exp_q.push_back({4'd5, period[63:48]});
        exp_q.push_back({4'd1, 16'h0007});
        cfg_period = period;
        cfg_start  = 1'b1;
        cfg_stop   = with_stop;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("load_consecutive_cs", {63'd0, avm_chipselect}, 64'd1);
            tick();
        end
        check("run_busy", {63'd0, busy}, 64'd1);
        check("run_bus_idle", {63'd0, avm_chipselect}, 64'd0);
    endtask

    task automatic do_irq(input logic [31:0] exp_cnt);
        bit seen;
        seen = 1'b0;
        exp_q.push_back({4'd0, 16'h0000});
        timer_irq = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (avm_chipselect && avm_address == 4'd0) seen = 1'b1;
        end
        check("irq_ack_seen", {63'd0, seen}, 64'd1);
        check("irq_tick_pulse", {63'd0, tick_pulse}, 64'd1);
        check("irq_tick_count", {32'd0, tick_count}, {32'd0, exp_cnt});
        timer_irq = 1'b0;
        tick();
        check("irq_pulse_once", {63'd0, tick_pulse}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cs", {63'd0, avm_chipselect}, 64'd0);
        check("rst_write_n", {63'd0, avm_write_n}, 64'd1);
        check("rst_addr", {60'd0, avm_address}, 64'd0);
        check("rst_tick_count", {32'd0, tick_count}, 64'd0);
        check("rst_snap_value", snap_value, 64'd0);
        check("rst_snap_valid", {63'd0, snap_valid}, 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();
        // Idle ignores stop, snapshot and irq
        cfg_stop = 1'b1; snap_req = 1'b1; timer_irq = 1'b1;
        tick();
        cfg_stop = 1'b0; snap_req = 1'b0;
        tick(); tick();
        timer_irq = 1'b0;
        check("idle_ignores_busy", {63'd0, busy}, 64'd0);

        // Load and run, then four serviced timeouts
        do_start(64'h0000_0000_0001_86A0, 1'b0);
        do_irq(32'd1);
        do_irq(32'd2);
        do_irq(32'd3);
        do_irq(32'd4);

        // Snapshot read
        slave_cnt = 64'h1122_3344_5566_7788;
        exp_q.push_back({4'd6, 16'h0000});
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("snw_addr", {60'd0, avm_address}, 64'd6);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("sr_cs_low", {63'd0, avm_chipselect}, 64'd0);
            check("sr_addr", {60'd0, avm_address}, 64'(6 + i));
            tick();
        end
        check("sr4_no_valid", {63'd0, snap_valid}, 64'd0);
        tick();
        check("snap_valid", {63'd0, snap_valid}, 64'd1);
        check("snap_value", snap_value, 64'h1122_3344_5566_7788);
        check("snap_back_in_run", {63'd0, busy}, 64'd1);
        tick();
        check("snap_valid_once", {63'd0, snap_valid}, 64'd0);
        check("snap_pulse_count", 64'(n_snapv), 64'd1);

        // Stop beats a same-cycle irq
        exp_q.push_back({4'd1, 16'h0008});
        timer_irq = 1'b1;
        cfg_stop  = 1'b1;
        tick();
        cfg_stop = 1'b0;
        check("stopw_no_pulse", {63'd0, tick_pulse}, 64'd0);
        check("stopw_data", {48'd0, avm_writedata}, 64'h8);
        tick();
        check("stop_idle", {63'd0, busy}, 64'd0);
        tick();
        timer_irq = 1'b0;
        check("stop_pulses", 64'(n_pulse), 64'd4);
        check("stop_keeps_count", {32'd0, tick_count}, 64'd4);

        // Start+stop together in idle acts as start; stop during SR2 waits for the snapshot
        do_start(64'h0123_4567_89AB_CDEF, 1'b1);
        check("restart_clears_count", {32'd0, tick_count}, 64'd0);
        slave_cnt = 64'hCAFE_BABE_DEAD_BEEF;
        exp_q.push_back({4'd6, 16'h0000});
        exp_q.push_back({4'd1, 16'h0008});
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        tick(); tick(); tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        tick(); tick();
        check("snap2_valid", {63'd0, snap_valid}, 64'd1);
        check("snap2_value", snap_value, 64'hCAFE_BABE_DEAD_BEEF);
        tick();
        check("snap2_stopw_cs", {63'd0, avm_chipselect}, 64'd1);
        check("snap2_stopw_addr", {60'd0, avm_address}, 64'd1);
        tick();
        check("snap2_idle", {63'd0, busy}, 64'd0);

        // tick_count wrap
        do_start(64'h0000_0000_0000_0010, 1'b0);
        force dut.tick_count_q = 32'hFFFF_FFFF;
        mod_ticks = 32'hFFFF_FFFF;
        tick();
        release dut.tick_count_q;
        tick();
        check("preload_count", {32'd0, tick_count}, 64'hFFFF_FFFF);
        do_irq(32'd0);

        // Reset in the middle of a load
        cfg_period = 64'h5555_6666_7777_8888;
        exp_q.push_back({4'd2, 16'h8888});
        exp_q.push_back({4'd3, 16'h7777});
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick(); tick();
        check("ld2_cs", {63'd0, avm_chipselect}, 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_cs", {63'd0, avm_chipselect}, 64'd0);
        check("mid_rst_write_n", {63'd0, avm_write_n}, 64'd1);
        check("mid_rst_wdata", {48'd0, avm_writedata}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_snap", snap_value, 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_idle", {63'd0, busy}, 64'd0);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("total_pulses", 64'(n_pulse), 64'd5);
        check("total_snap_valid", 64'(n_snapv), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
